hex_char_rotator: RTL and testbench
===================================

# hex_char_rotator

Sequential source for the four-character rotating HEX display. It accepts four 2-bit character codes over a valid/ready load interface and stores them in a buffer. It then rotates the buffer automatically on a prescaled tick, or on manual steps when configured. It drives the four rotated 2-bit codes that the HEX character decoders consume, replacing the static switch preset and switch-driven rotation select.

## Interface
- TICK_DIV, default 50000000: CLOCK_50 cycles per rotation step; legal range is 1 or more.
- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- Resetn  in  1  synchronous, active-low reset.
- load_valid  in  1  a character is presented on load_char.
- load_char  in  2  character code to load.
- load_ready  out  1  block accepts a character this cycle.
- run  in  1  1 = rotate, 0 = pause.
- dir  in  1  0 = offset increments, 1 = offset decrements.
- clr  in  1  pulse; empties the buffer and restarts loading.
- F  out  8  rotated codes; F[7:6] drives HEX3 and F[1:0] drives HEX0.
- offset  out  2  current rotation offset.
- step_pulse  out  1  high for one cycle when offset changes.
- step  in  1  manual advance pulse; this port is present only with the macro in Configuration.

## Operation
- Buffer: char[0..3], 2 bits each. The loaded character at index k is written to char[k].
- Output map: F = {char[offset], char[(offset+1)%4], char[(offset+2)%4], char[(offset+3)%4]}. F is combinational from the registers.
- The state machine has three states: LOAD, READY and ROTATE.
  - LOAD: load_ready = 1. A character is accepted when load_valid && load_ready. An accepted character is written to char[cnt], and cnt (2 bits) increments. The 4th accept moves the state to READY. run is ignored in LOAD.
  - READY: load_ready = 0. run = 1 moves the state to ROTATE.
  - ROTATE: the prescaler counts 0..TICK_DIV-1. At the terminal count the prescaler wraps to 0 and offset is updated: +1 mod 4 if dir = 0, -1 mod 4 if dir = 1. step_pulse = 1 in that same cycle. run = 0 moves the state to READY; the prescaler and offset hold, so the rotation is paused.
- clr in any state:
  - state goes to LOAD;
  - cnt, offset, prescaler and all chars go to 0.
- Priority order: Resetn, then clr, then all other inputs.
- dir is sampled only at the terminal count, so a change takes effect at the next step.
- A load_valid pulse outside LOAD is dropped and has no effect.
- load_valid may deassert between characters; cnt holds while it is low.

## Timing
- Values after the first CLOCK_50 edge with Resetn = 0:
  - state LOAD, cnt 0, offset 0, prescaler 0, buffer 0;
  - F = 8'h00, load_ready = 1, step_pulse = 0.
- Load: a character accepted on edge n is visible on F after edge n. The 4th accept drops load_ready after that same edge.
- Rotation: entering ROTATE on edge n places the first offset change on edge n+TICK_DIV. step_pulse is high in the cycle before that edge, aligned with the terminal count. Offset changes every TICK_DIV cycles after that.
- TICK_DIV = 1: offset changes on every ROTATE cycle.
- A clr asserted on edge n shows state LOAD and F = 8'h00 after edge n. A load_valid in that same cycle is ignored.
- Resetn low during loading discards any partial load. Resetn low during ROTATE stops rotation at the next edge.

## Configuration
- HEX_STEP_KEY_EN defined:
  - the step input exists;
  - in READY, a step pulse advances offset once by dir, using the same rule as a tick;
  - step_pulse = 1 in that cycle;
  - step is ignored in LOAD and ROTATE;
  - step is intended for a debounced, edge-detected KEY.
- HEX_STEP_KEY_EN not defined: the step port and its logic are absent, and offset changes only in ROTATE.

## Test plan
- Reset: hold Resetn = 0 for 2 cycles, then release. Expect load_ready = 1, F = 8'h00, offset = 0, step_pulse = 0.
- Load: present load_char 3,2,1,0 with load_valid held high. Expect F = 8'hE4 and load_ready = 0 after the 4th edge. A 5th load_valid leaves F unchanged.
- Rotate with TICK_DIV = 4, run = 1, dir = 0 from 8'hE4:
  - after 4 cycles, offset = 1 and F = 8'h93, with one step_pulse;
  - after 16 cycles, offset = 0 and F = 8'hE4;
  - run = 0 mid-count holds offset; a later run = 1 resumes from the same prescaler value.
- Reverse: dir = 1 from offset 0. Expect offset = 3 and F = 8'h39 after 4 cycles.
- clr during ROTATE with offset = 2: after one edge, F = 8'h00, offset = 0 and load_ready = 1. Then reload 1,1,0,0 with load_valid gaps and expect F = 8'h50.
- Resetn low after 2 accepted characters: expect cnt = 0 and F = 8'h00. The next 4 accepts fill slots 0..3 in order.
- With HEX_STEP_KEY_EN defined, a step in READY with dir = 0 moves offset 0→1 and F 8'hE4→8'h93. A step in ROTATE causes no extra change.

Source files
------------

// File: rtl/hex_char_rotator.sv
// hex_char_rotator: buffers four 2-bit HEX character codes and rotates them on a prescaled tick.
// Define HEX_STEP_KEY_EN to add a manual step input that advances the rotation while paused.
module hex_char_rotator #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       load_valid,
  input  logic [1:0] load_char,
  output logic       load_ready,
  input  logic       run,
  input  logic       dir,
  input  logic       clr,
`ifdef HEX_STEP_KEY_EN
  input  logic       step,
`endif
  output logic [7:0] F,
  output logic [1:0] offset,
  output logic       step_pulse
);

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    LOAD,
    READY,
    ROTATE
  } state_t;

  state_t        state;
  logic [1:0]    cnt;
  logic [PW-1:0] prescaler;
  logic [1:0]    chars [4];

  logic          tick_hit;
  logic          manual_hit;
  logic          advance;
  logic [1:0]    next_offset;
  logic [1:0]    idx1;
  logic [1:0]    idx2;
  logic [1:0]    idx3;

  // A paused rotation (run low in ROTATE) must not count or advance, so run gates the tick.
  assign tick_hit = (state == ROTATE) && run && (prescaler == TERM);

`ifdef HEX_STEP_KEY_EN
  assign manual_hit = (state == READY) && step;
`else
  assign manual_hit = 1'b0;
`endif

  assign advance     = Resetn && !clr && (tick_hit || manual_hit);
  assign step_pulse  = advance;
  assign next_offset = dir ? (offset - 2'd1) : (offset + 2'd1);
  assign load_ready  = (state == LOAD);

  assign idx1 = offset + 2'd1;
  assign idx2 = offset + 2'd2;
  assign idx3 = offset + 2'd3;
  assign F    = {chars[offset], chars[idx1], chars[idx2], chars[idx3]};

  // clr behaves like a reset, but below Resetn in priority; both wipe any partial load.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn || clr) begin
      state     <= LOAD;
      cnt       <= 2'd0;
      offset    <= 2'd0;
      prescaler <= '0;
      for (int k = 0; k < 4; k++) begin
        chars[k] <= 2'd0;
      end
    end else begin
      if (advance) begin
        offset <= next_offset;
      end
      case (state)
        LOAD: begin
          if (load_valid) begin
            chars[cnt] <= load_char;
            cnt        <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state <= READY;
            end
          end
        end
        READY: begin
          if (run) begin
            state <= ROTATE;
          end
        end
        ROTATE: begin
          if (!run) begin
            state <= READY;
          end else if (prescaler == TERM) begin
            prescaler <= '0;
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_char_rotator.sv
// Self-checking bench for hex_char_rotator with TICK_DIV = 4; expected results flow through a scoreboard queue.
// Step-key scenario is exercised only when HEX_STEP_KEY_EN is defined.
module tb_hex_char_rotator;

  localparam int TICK_DIV = 4;

  logic       CLOCK_50   = 1'b0;
  logic       Resetn     = 1'b0;
  logic       load_valid = 1'b0;
  logic [1:0] load_char  = 2'd0;
  logic       run        = 1'b0;
  logic       dir        = 1'b0;
  logic       clr        = 1'b0;
  logic       load_ready;
  logic [7:0] F;
  logic [1:0] offset;
  logic       step_pulse;
`ifdef HEX_STEP_KEY_EN
  logic       step       = 1'b0;
`endif

  int passed = 0;
  int total  = 0;

  typedef struct {
    string      tag;
    logic [7:0] f;
    logic [1:0] off;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  always #5 CLOCK_50 = ~CLOCK_50;

  hex_char_rotator #(.TICK_DIV(TICK_DIV)) dut (
    .CLOCK_50  (CLOCK_50),
    .Resetn    (Resetn),
    .load_valid(load_valid),
    .load_char (load_char),
    .load_ready(load_ready),
    .run       (run),
    .dir       (dir),
    .clr       (clr),
`ifdef HEX_STEP_KEY_EN
    .step      (step),
`endif
    .F         (F),
    .offset    (offset),
    .step_pulse(step_pulse)
  );

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    Resetn = 1'b0;
    sb.push_back('{"reset_hold", 8'h00, 2'd0, 1'b1});
    tick(2);
    e = sb.pop_front();
    total++;
    if (F !== e.f || offset !== e.off || load_ready !== e.rdy || step_pulse !== 1'b0)
      $display("[TB] FAIL %s: F=%h offset=%0d ready=%b pulse=%b, required F=%h offset=%0d ready=%b pulse=0",
               e.tag, F, offset, load_ready, step_pulse, e.f, e.off, e.rdy);
    else passed++;
    Resetn = 1'b1;
    sb.push_back('{"reset_release", 8'h00, 2'd0, 1'b1});
    tick(1);
    e = sb.pop_front();
    total++;
    if (F !== e.f || offset !== e.off || load_ready !== e.rdy || step_pulse !== 1'b0)
      $display("[TB] FAIL %s: F=%h offset=%0d ready=%b pulse=%b, required F=%h offset=%0d ready=%b pulse=0",
               e.tag, F, offset, load_ready, step_pulse, e.f, e.off, e.rdy);
    else passed++;
  endtask

  task automatic test_load();
    logic [1:0] codes [4]    = '{2'd3, 2'd2, 2'd1, 2'd0};
    logic [7:0] f_after [4]  = '{8'hC0, 8'hE0, 8'hE4, 8'hE4};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_char  = codes[i];
      sb.push_back('{$sformatf("load_%0d", i), f_after[i], 2'd0, (i < 3)});
      tick(1);
      e = sb.pop_front();
      total++;
      if (F !== e.f || offset !== e.off || load_ready !== e.rdy)
        $display("[TB] FAIL %s: F=%h offset=%0d ready=%b, required F=%h offset=%0d ready=%b",
                 e.tag, F, offset, load_ready, e.f, e.off, e.rdy);
      else passed++;
    end
    load_char = 2'd3;
    sb.push_back('{"load_fifth_dropped", 8'hE4, 2'd0, 1'b0});
    tick(1);
    load_valid = 1'b0;
    e = sb.pop_front();
    total++;
    if (F !== e.f || offset !== e.off || load_ready !== e.rdy)
      $display("[TB] FAIL %s: F=%h offset=%0d ready=%b, required F=%h offset=%0d ready=%b",
               e.tag, F, offset, load_ready, e.f, e.off, e.rdy);
    else passed++;
  endtask

  task automatic test_rotate();
    logic [7:0] f_by_off [4] = '{8'hE4, 8'h93, 8'h4E, 8'h39};
    exp_t e;
    int pulses;
    int off_model;
    run = 1'b1;
    dir = 1'b0;
    tick(1);
    off_model = 0;
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      if (step_pulse === 1'b1) pulses++;
      if (k % TICK_DIV == 0) off_model = (off_model + 1) % 4;
      sb.push_back('{$sformatf("rotate_cycle_%0d", k), f_by_off[off_model], 2'(off_model), 1'b0});
      tick(1);
      if (k % TICK_DIV == 0 || k == 1) begin
        e = sb.pop_front();
        total++;
        if (F !== e.f || offset !== e.off || load_ready !== e.rdy)
          $display("[TB] FAIL %s: F=%h offset=%0d ready=%b, required F=%h offset=%0d ready=%b",
                   e.tag, F, offset, load_ready, e.f, e.off, e.rdy);
        else passed++;
      end else begin
        void'(sb.pop_front());
      end
      if (k == 4) begin
        total++;
        if (pulses !== 1)
          $display("[TB] FAIL rotate_first_pulse_count: saw %0d pulses, required 1", pulses);
        else passed++;
      end
    end
    total++;
    if (pulses !== 4)
      $display("[TB] FAIL rotate_pulse_count: saw %0d pulses, required 4", pulses);
    else passed++;
  endtask

  task automatic test_pause_resume();
    exp_t e;
    int pulses;
    tick(2);
    run = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      if (step_pulse === 1'b1) pulses++;
    end
    sb.push_back('{"pause_hold", 8'hE4, 2'd0, 1'b0});
    e = sb.pop_front();
    total++;
    if (F !== e.f || offset !== e.off || load_ready !== e.rdy || pulses !== 0)
      $display("[TB] FAIL %s: F=%h offset=%0d ready=%b pulses=%0d, required F=%h offset=%0d ready=%b pulses=0",
               e.tag, F, offset, load_ready, pulses, e.f, e.off, e.rdy);
    else passed++;
    run = 1'b1;
    sb.push_back('{"resume_tick_1", 8'hE4, 2'd0, 1'b0});
    sb.push_back('{"resume_tick_2", 8'h93, 2'd1, 1'b0});
    tick(2);
    e = sb.pop_front();
    total++;
    if (F !== e.f || offset !== e.off || load_ready !== e.rdy)
      $display("[TB] FAIL %s: F=%h offset=%0d ready=%b, required F=%h offset=%0d ready=%b",
               e.tag, F, offset, load_ready, e.f, e.off, e.rdy);
    else passed++;
    tick(1);
    e = sb.pop_front();
    total++;
    if (F !== e.f || offset !== e.off || load_ready !== e.rdy)
      $display("[TB] FAIL %s: F=%h offset=%0d ready=%b, required F=%h offset=%0d ready=%b",
               e.tag, F, offset, load_ready, e.f, e.off, e.rdy);
    else passed++;
  endtask

  task automatic test_reverse();
    logic [7:0] f_exp [3]   = '{8'hE4, 8'h39, 8'h4E};
    logic [1:0] off_exp [3] = '{2'd0, 2'd3, 2'd2};
    exp_t e;
    dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{$sformatf("reverse_step_%0d", i), f_exp[i], off_exp[i], 1'b0});
      tick(TICK_DIV);
      e = sb.pop_front();
      total++;
      if (F !== e.f || offset !== e.off || load_ready !== e.rdy)
        $display("[TB] FAIL %s: F=%h offset=%0d ready=%b, required F=%h offset=%0d ready=%b",
                 e.tag, F, offset, load_ready, e.f, e.off, e.rdy);
      else passed++;
    end
  endtask

  task automatic test_clr_reload();
    logic       valid_seq [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] char_seq [6]  = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd0};
    logic [7:0] f_seq [6]     = '{8'h40, 8'h40, 8'h50, 8'h50, 8'h50, 8'h50};
    logic       rdy_seq [6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_t e;
    tick(1);
    clr        = 1'b1;
    load_valid = 1'b1;
    load_char  = 2'd3;
    sb.push_back('{"clr_in_rotate", 8'h00, 2'd0, 1'b1});
    tick(1);
    clr        = 1'b0;
    load_valid = 1'b0;
    run        = 1'b0;
    dir        = 1'b0;
    e = sb.pop_front();
    total++;
    if (F !== e.f || offset !== e.off || load_ready !== e.rdy)
      $display("[TB] FAIL %s: F=%h offset=%0d ready=%b, required F=%h offset=%0d ready=%b",
               e.tag, F, offset, load_ready, e.f, e.off, e.rdy);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      load_valid = valid_seq[i];
      load_char  = char_seq[i];
      sb.push_back('{$sformatf("reload_%0d", i), f_seq[i], 2'd0, rdy_seq[i]});
      tick(1);
      e = sb.pop_front();
      total++;
      if (F !== e.f || offset !== e.off || load_ready !== e.rdy)
        $display("[TB] FAIL %s: F=%h offset=%0d ready=%b, required F=%h offset=%0d ready=%b",
                 e.tag, F, offset, load_ready, e.f, e.off, e.rdy);
      else passed++;
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [1:0] codes [6]  = '{2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] f_exp [6]  = '{8'h80, 8'hB0, 8'h40, 8'h60, 8'h6C, 8'h6C};
    logic       rdy_exp [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_t e;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        Resetn = 1'b0;
        sb.push_back('{"reset_mid_load", 8'h00, 2'd0, 1'b1});
        tick(1);
        Resetn = 1'b1;
        e = sb.pop_front();
        total++;
        if (F !== e.f || offset !== e.off || load_ready !== e.rdy)
          $display("[TB] FAIL %s: F=%h offset=%0d ready=%b, required F=%h offset=%0d ready=%b",
                   e.tag, F, offset, load_ready, e.f, e.off, e.rdy);
        else passed++;
      end
      load_valid = 1'b1;
      load_char  = codes[i];
      sb.push_back('{$sformatf("partial_load_%0d", i), f_exp[i], 2'd0, rdy_exp[i]});
      tick(1);
      e = sb.pop_front();
      total++;
      if (F !== e.f || offset !== e.off || load_ready !== e.rdy)
        $display("[TB] FAIL %s: F=%h offset=%0d ready=%b, required F=%h offset=%0d ready=%b",
                 e.tag, F, offset, load_ready, e.f, e.off, e.rdy);
      else passed++;
    end
    load_valid = 1'b0;
  endtask

`ifdef HEX_STEP_KEY_EN
  task automatic test_step_key();
    exp_t e;
    logic pulse_seen;
    dir  = 1'b0;
    step = 1'b1;
    #1 pulse_seen = step_pulse;
    sb.push_back('{"step_in_ready", 8'hB1, 2'd1, 1'b0});
    tick(1);
    step = 1'b0;
    e = sb.pop_front();
    total++;
    if (F !== e.f || offset !== e.off || load_ready !== e.rdy || pulse_seen !== 1'b1)
      $display("[TB] FAIL %s: F=%h offset=%0d ready=%b pulse=%b, required F=%h offset=%0d ready=%b pulse=1",
               e.tag, F, offset, load_ready, pulse_seen, e.f, e.off, e.rdy);
    else passed++;
    run = 1'b1;
    tick(1);
    step = 1'b1;
    sb.push_back('{"step_in_rotate", 8'hB1, 2'd1, 1'b0});
    tick(1);
    step = 1'b0;
    e = sb.pop_front();
    total++;
    if (F !== e.f || offset !== e.off || load_ready !== e.rdy)
      $display("[TB] FAIL %s: F=%h offset=%0d ready=%b, required F=%h offset=%0d ready=%b",
               e.tag, F, offset, load_ready, e.f, e.off, e.rdy);
    else passed++;
    run = 1'b0;
  endtask
`endif

  initial begin
    @(negedge CLOCK_50);
    test_reset();
    test_load();
    test_rotate();
    test_pause_resume();
    test_reverse();
    test_clr_reload();
    test_reset_mid_load();
`ifdef HEX_STEP_KEY_EN
    test_step_key();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
